// File: rtl/arb8_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb8_ctrl_pkg
// Description : Shared definitions for the 8-way arbiter controller:
//               FSM state encoding, requester count, index width and a
//               one-hot decode helper.
// Ports       : none (package)
// Config      : ARB8_CTRL_RR_EN is consumed by arb8_ctrl, not here.
// Revision    : 1.0 - initial release
// ============================================================================
package arb8_ctrl_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    // Binary index to one-hot requester vector.
    function automatic logic [NUM_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage : arb8_ctrl_pkg
`default_nettype wire

// File: rtl/arb8_ctrl_prio_enc8.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc8
// Description : Combinational 8-to-3 priority encoder. The highest-index
//               set bit wins; vld_o flags that at least one bit is set.
//               idx_o is 3'b000 when no bit is set.
// Ports       : req_i [7:0] request vector
//               idx_o [2:0] index of highest set bit
//               vld_o       any bit set
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc8
    import arb8_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);

    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        // Ascending scan: the last (highest) set bit overwrites earlier ones.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
                vld_o = 1'b1;
            end
        end
    end

endmodule : prio_enc8
`default_nettype wire

// File: rtl/arb8_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arb8_ctrl
// Description : 8-requester arbiter for a shared resource. IDLE -> GRANT ->
//               RELEASE FSM with registered outputs, a hold counter that
//               force-releases a grant after HOLD_MAX cycles without done,
//               and a mandatory one-cycle RELEASE bubble between grants.
// Parameters  : HOLD_MAX  max grant cycles before forced release (2..255)
// Ports       : clk      clock, rising edge
//               rst_n    asynchronous active-low reset
//               req      [7:0] request levels
//               done     transaction-finished pulse
//               gnt      [7:0] one-hot grant (registered)
//               gnt_id   [2:0] granted index, 0 when no grant
//               gnt_vld  grant present
//               timeout  one-cycle pulse on forced release
// Config      : `define ARB8_CTRL_RR_EN selects round-robin arbitration;
//               otherwise fixed priority (bit 7 highest).
// Revision    : 1.0 - initial release
// ============================================================================
module arb8_ctrl
    import arb8_ctrl_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               gnt_vld,
    output logic               timeout
);

    localparam logic [7:0] c_hold_last = 8'(HOLD_MAX - 1);

    state_e             state_q,   state_d;
    logic [NUM_REQ-1:0] gnt_q,     gnt_d;
    logic [IDX_W-1:0]   gnt_id_q,  gnt_id_d;
    logic               gnt_vld_q, gnt_vld_d;
    logic               timeout_q, timeout_d;
    logic [7:0]         cnt_q,     cnt_d;

    logic [IDX_W-1:0]   w_win_idx;
    logic               w_win_vld;
    logic               w_release;
    logic               w_expire;

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
`ifdef ARB8_CTRL_RR_EN
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] w_below_mask;
    logic [IDX_W-1:0]   w_m_idx, w_f_idx;
    logic               w_m_vld, w_f_vld;

    // Bits strictly below the last granted index; empty when pointer is 0,
    // which makes the unmasked encoder decide (highest index overall).
    assign w_below_mask = (NUM_REQ'(1) << ptr_q) - NUM_REQ'(1);

    prio_enc8 u_enc_masked (
        .req_i (req & w_below_mask),
        .idx_o (w_m_idx),
        .vld_o (w_m_vld)
    );

    prio_enc8 u_enc_full (
        .req_i (req),
        .idx_o (w_f_idx),
        .vld_o (w_f_vld)
    );

    assign w_win_idx = w_m_vld ? w_m_idx : w_f_idx;
    assign w_win_vld = w_f_vld;
`else
    prio_enc8 u_enc (
        .req_i (req),
        .idx_o (w_win_idx),
        .vld_o (w_win_vld)
    );
`endif

    // Release conditions take precedence over expiry so that a done or a
    // dropped request coincident with expiry never raises timeout.
    assign w_release = done | ~req[gnt_id_q];
    assign w_expire  = (cnt_q == c_hold_last);

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        gnt_vld_d = gnt_vld_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
`ifdef ARB8_CTRL_RR_EN
        ptr_d     = ptr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                gnt_d     = '0;
                gnt_id_d  = '0;
                gnt_vld_d = 1'b0;
                cnt_d     = '0;
                if (w_win_vld) begin
                    state_d   = ST_GRANT;
                    gnt_d     = onehot8(w_win_idx);
                    gnt_id_d  = w_win_idx;
                    gnt_vld_d = 1'b1;
`ifdef ARB8_CTRL_RR_EN
                    ptr_d     = w_win_idx;
`endif
                end
            end

            ST_GRANT: begin
                if (w_release || w_expire) begin
                    state_d   = ST_RELEASE;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    gnt_vld_d = 1'b0;
                    timeout_d = ~w_release;
                    cnt_d     = '0;
                end else if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            ST_RELEASE: begin
                state_d   = ST_IDLE;
                gnt_d     = '0;
                gnt_id_d  = '0;
                gnt_vld_d = 1'b0;
                cnt_d     = '0;
            end

            default: begin
                state_d   = ST_IDLE;
                gnt_d     = '0;
                gnt_id_d  = '0;
                gnt_vld_d = 1'b0;
                cnt_d     = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            gnt_vld_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            gnt_vld_q <= gnt_vld_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef ARB8_CTRL_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign gnt_vld = gnt_vld_q;
    assign timeout = timeout_q;

endmodule : arb8_ctrl
`default_nettype wire

// File: tb/tb_arb8_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb8_ctrl
// Description : Directed self-checking bench for arb8_ctrl (HOLD_MAX=4).
//               Expected values are hand-computed; round-robin expectations
//               are selected when ARB8_CTRL_RR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb8_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    arb8_ctrl #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full output check: gnt vector, id, vld, timeout.
    task automatic chk_out(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_id,
                           input logic e_vld, input logic e_to);
        chk({tag, ".gnt"},     gnt,             e_gnt);
        chk({tag, ".gnt_id"},  {5'd0, gnt_id},  {5'd0, e_id});
        chk({tag, ".gnt_vld"}, {7'd0, gnt_vld}, {7'd0, e_vld});
        chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, e_to});
    endtask

    logic [2:0] exp_id;

    initial begin
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        tick();
        tick();
        chk_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Basic grant: highest index of 0x24 is 5
        req = 8'h24;
        tick();
        chk_out("grant5", 8'h20, 3'd5, 1'b1, 1'b0);

        // done -> RELEASE, then IDLE, then re-arbitrate
        done = 1'b1;
        tick();
        chk_out("rel_done", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;
        tick();
        chk_out("idle_after_rel", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
`ifdef ARB8_CTRL_RR_EN
        chk_out("regrant", 8'h04, 3'd2, 1'b1, 1'b0);
`else
        chk_out("regrant", 8'h20, 3'd5, 1'b1, 1'b0);
`endif

        // Drop request -> release; all-zero req stays idle
        req = 8'h00;
        tick();
        chk_out("rel_drop", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();
        tick();
        chk_out("idle_zero", 8'h00, 3'd0, 1'b0, 1'b0);

        // Expiry: 4 grant cycles then timeout pulse with RELEASE
        req = 8'h01;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk_out($sformatf("hold_c%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
        end
        tick();
        chk_out("expire", 8'h00, 3'd0, 1'b0, 1'b1);
        tick();
        chk_out("expire_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // done on the 4th grant cycle beats expiry
        tick();
        chk_out("done_exp_c1", 8'h01, 3'd0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk_out("done_exp_c4", 8'h01, 3'd0, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        chk_out("done_exp_rel", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;
        req  = 8'h00;
        tick();

        // Request drop coincident with expiry: no timeout
        req = 8'h01;
        tick();
        tick();
        tick();
        tick();
        chk_out("drop_exp_c4", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        chk_out("drop_exp_rel", 8'h00, 3'd0, 1'b0, 1'b0);
        tick();

        // Non-granted bits changing during GRANT do not move the grant
        req = 8'h04;
        tick();
        chk_out("lowgrant", 8'h04, 3'd2, 1'b1, 1'b0);
        req = 8'h84;
        tick();
        chk_out("hold_vs_high", 8'h04, 3'd2, 1'b1, 1'b0);
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();
        chk_out("high_after", 8'h80, 3'd7, 1'b1, 1'b0);

        // done in RELEASE/IDLE is ignored
        req  = 8'h00;
        tick();
        done = 1'b1;
        tick();
        tick();
        chk_out("done_idle", 8'h00, 3'd0, 1'b0, 1'b0);
        done = 1'b0;

        // Asynchronous reset mid-grant
        req = 8'h24;
        tick();
        chk_out("pre_rst", 8'h20, 3'd5, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        chk_out("post_rst", 8'h20, 3'd5, 1'b1, 1'b0);

        // Sweep with all requesters active, done after each grant
        done  = 1'b1;
        tick();
        done  = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = 8'hFF;
        for (int k = 0; k < 9; k++) begin
`ifdef ARB8_CTRL_RR_EN
            exp_id = 3'(7 - k);
`else
            exp_id = 3'd7;
`endif
            tick();
            chk_out($sformatf("sweep_%0d", k), 8'h01 << exp_id, exp_id, 1'b1, 1'b0);
            done = 1'b1;
            tick();
            done = 1'b0;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_arb8_ctrl
`default_nettype wire
